// File: rtl/vga_arb_pkg.sv
// vga_arb_pkg: shared widths, default screen size, arbiter state encoding and
// an on-screen test used by the vga_adapter plot arbiter.
package vga_arb_pkg;

  localparam int X_W       = 9;
  localparam int Y_W       = 8;
  localparam int COL_W     = 3;
  localparam int X_MAX_DEF = 320;
  localparam int Y_MAX_DEF = 240;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    GRANT = 2'b01,
    GAP   = 2'b10
  } arb_state_t;

  // True when the pixel lies inside the visible x_max by y_max area.
  function automatic logic pix_on_screen(input logic [X_W-1:0] x,
                                         input logic [Y_W-1:0] y,
                                         input int             x_max,
                                         input int             y_max);
    pix_on_screen = (int'({1'b0, x}) < x_max) && (int'({1'b0, y}) < y_max);
  endfunction

endpackage

// File: rtl/vga_plot_arbiter_if.sv
// vga_plot_arbiter_if: bundle between NUM_REQ pixel producers and the plot
// arbiter that drives the vga_adapter write port.
//   producer side : req, plot_in, last_in, x_in, y_in, color_in (packed per producer)
//   display side  : gnt, plot, X, Y, color, busy, timeout_err
// master = the producers, slave = the arbiter.
interface vga_plot_arbiter_if #(
  parameter int NUM_REQ = 3
) ();
  import vga_arb_pkg::*;

  logic [NUM_REQ-1:0]       req;
  logic [NUM_REQ-1:0]       plot_in;
  logic [NUM_REQ-1:0]       last_in;
  logic [X_W*NUM_REQ-1:0]   x_in;
  logic [Y_W*NUM_REQ-1:0]   y_in;
  logic [COL_W*NUM_REQ-1:0] color_in;

  logic [NUM_REQ-1:0]       gnt;
  logic                     plot;
  logic [X_W-1:0]           X;
  logic [Y_W-1:0]           Y;
  logic [COL_W-1:0]         color;
  logic                     busy;
  logic                     timeout_err;

  modport master (
    output req, plot_in, last_in, x_in, y_in, color_in,
    input  gnt, plot, X, Y, color, busy, timeout_err
  );

  modport slave (
    input  req, plot_in, last_in, x_in, y_in, color_in,
    output gnt, plot, X, Y, color, busy, timeout_err
  );

endinterface

// File: rtl/vga_rr_pick.sv
// vga_rr_pick: combinational round-robin picker. Scans req starting one
// position after last_winner (wrapping) and returns the first requester.
//   req         : request vector
//   last_winner : index granted most recently
//   grant       : one-hot of the chosen requester (zero when none)
//   idx         : encoded index of the chosen requester
//   any         : at least one request is present
module vga_rr_pick import vga_arb_pkg::*; #(
  parameter int NUM_REQ = 3,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   last_winner,
  output logic [NUM_REQ-1:0] grant,
  output logic [IDX_W-1:0]   idx,
  output logic               any
);

  logic             found_s;
  logic             hit_s;
  logic [IDX_W-1:0] idx_s;

  // Rotating priority scan; the first hit after last_winner wins.
  always_comb begin : rr_scan
    int cand;
    found_s = 1'b0;
    hit_s   = 1'b0;
    idx_s   = '0;
    cand    = 0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand    = (int'(last_winner) + k) % NUM_REQ;
      hit_s   = !found_s && req[cand];
      idx_s   = hit_s ? IDX_W'(cand) : idx_s;
      found_s = found_s | hit_s;
    end
  end

  assign idx   = idx_s;
  assign any   = found_s;
  assign grant = found_s ? ({{(NUM_REQ-1){1'b0}}, 1'b1} << idx_s) : {NUM_REQ{1'b0}};

endmodule

// File: rtl/vga_plot_arbiter.sv
// vga_plot_arbiter: shares the single vga_adapter plot port among NUM_REQ
// pixel producers. One producer holds the grant for a whole burst; its pixels
// are clipped to X_MAX x Y_MAX and forwarded through one register stage.
// A burst ends on last, on a dropped req, or after TIMEOUT idle cycles.
//   clock, reset : system clock, asynchronous active-high reset
//   bus (slave)  : producer requests/pixels in, grant and vga_adapter write out
module vga_plot_arbiter import vga_arb_pkg::*; #(
  parameter int NUM_REQ = 3,
  parameter int TIMEOUT = 1024,
  parameter int X_MAX   = X_MAX_DEF,
  parameter int Y_MAX   = Y_MAX_DEF
) (
  input logic               clock,
  input logic               reset,
  vga_plot_arbiter_if.slave bus
);

  localparam int IDX_W = $clog2(NUM_REQ);
  localparam int WD_W  = $clog2(TIMEOUT) + 1;
  localparam logic [WD_W-1:0]  WD_LIM   = WD_W'(TIMEOUT - 1);
  localparam logic [IDX_W-1:0] LAST_RST = IDX_W'(NUM_REQ - 1);

  arb_state_t         state_r, state_nx_s;
  logic [NUM_REQ-1:0] gnt_r, gnt_nx_s;
  logic [IDX_W-1:0]   g_r, g_nx_s;
  logic [IDX_W-1:0]   last_winner_r, last_nx_s;
  logic [WD_W-1:0]    wd_r, wd_nx_s;
  logic               plot_r, plot_nx_s;
  logic [X_W-1:0]     x_r, x_nx_s;
  logic [Y_W-1:0]     y_r, y_nx_s;
  logic [COL_W-1:0]   col_r, col_nx_s;
  logic               busy_r;
  logic               terr_r, terr_nx_s;

  logic [NUM_REQ-1:0] pick_onehot_s;
  logic [IDX_W-1:0]   pick_idx_s;
  logic               pick_any_s;

  logic               plot_g_s, last_g_s, req_g_s;
  logic [X_W-1:0]     x_g_s;
  logic [Y_W-1:0]     y_g_s;
  logic [COL_W-1:0]   col_g_s;

  vga_rr_pick #(.NUM_REQ(NUM_REQ), .IDX_W(IDX_W)) u_pick (
    .req         (bus.req),
    .last_winner (last_winner_r),
    .grant       (pick_onehot_s),
    .idx         (pick_idx_s),
    .any         (pick_any_s)
  );

  // Select the granted producer's lane; all other lanes are ignored.
  always_comb begin
    plot_g_s = bus.plot_in[g_r];
    last_g_s = bus.last_in[g_r];
    req_g_s  = bus.req[g_r];
    x_g_s    = bus.x_in[g_r*X_W +: X_W];
    y_g_s    = bus.y_in[g_r*Y_W +: Y_W];
    col_g_s  = bus.color_in[g_r*COL_W +: COL_W];
  end

  // Next-state, grant, watchdog and pixel-stage logic.
  always_comb begin
    state_nx_s = state_r;
    gnt_nx_s   = gnt_r;
    g_nx_s     = g_r;
    last_nx_s  = last_winner_r;
    wd_nx_s    = wd_r;
    plot_nx_s  = 1'b0;
    x_nx_s     = x_r;
    y_nx_s     = y_r;
    col_nx_s   = col_r;
    terr_nx_s  = 1'b0;
    case (state_r)
      IDLE: begin
        if (pick_any_s) begin
          state_nx_s = GRANT;
          gnt_nx_s   = pick_onehot_s;
          g_nx_s     = pick_idx_s;
          last_nx_s  = pick_idx_s;
          wd_nx_s    = '0;
        end else begin
          state_nx_s = IDLE;
        end
      end
      GRANT: begin
        // Coordinates track the lane every cycle; only plot is qualified.
        x_nx_s    = x_g_s;
        y_nx_s    = y_g_s;
        col_nx_s  = col_g_s;
        plot_nx_s = plot_g_s & req_g_s & pix_on_screen(x_g_s, y_g_s, X_MAX, Y_MAX);
        // Release priority: last, then req drop, then watchdog.
        if (plot_g_s && last_g_s) begin
          state_nx_s = GAP;
          gnt_nx_s   = '0;
        end else if (!req_g_s) begin
          state_nx_s = GAP;
          gnt_nx_s   = '0;
        end else if (!plot_g_s && (wd_r >= WD_LIM)) begin
          state_nx_s = GAP;
          gnt_nx_s   = '0;
          terr_nx_s  = 1'b1;
        end else if (plot_g_s) begin
          wd_nx_s = '0;
        end else if (wd_r != {WD_W{1'b1}}) begin
          wd_nx_s = wd_r + WD_W'(1);
        end else begin
          wd_nx_s = wd_r;
        end
      end
      GAP: begin
        state_nx_s = IDLE;
        gnt_nx_s   = '0;
      end
      default: begin
        state_nx_s = IDLE;
        gnt_nx_s   = '0;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_r       <= IDLE;
      gnt_r         <= '0;
      g_r           <= '0;
      last_winner_r <= LAST_RST;
      wd_r          <= '0;
      plot_r        <= 1'b0;
      x_r           <= '0;
      y_r           <= '0;
      col_r         <= '0;
      busy_r        <= 1'b0;
      terr_r        <= 1'b0;
    end else begin
      state_r       <= state_nx_s;
      gnt_r         <= gnt_nx_s;
      g_r           <= g_nx_s;
      last_winner_r <= last_nx_s;
      wd_r          <= wd_nx_s;
      plot_r        <= plot_nx_s;
      x_r           <= x_nx_s;
      y_r           <= y_nx_s;
      col_r         <= col_nx_s;
      busy_r        <= (state_nx_s != IDLE);
      terr_r        <= terr_nx_s;
    end
  end

  assign bus.gnt         = gnt_r;
  assign bus.plot        = plot_r;
  assign bus.X           = x_r;
  assign bus.Y           = y_r;
  assign bus.color       = col_r;
  assign bus.busy        = busy_r;
  assign bus.timeout_err = terr_r;

endmodule
